row_hit_chain_builder: RTL and testbench

Batch post-processor sitting directly downstream of the request buffer. After a batch is closed it walks buffered requests 0..N-1 in order, uses the buffer's read port and hit-tag CAM to find the oldest request sharing each request's {bank group, bank, row} tag, and writes chain links so that same-row requests form singly-linked lists in arrival order. It reports each chain head and the chain count to the scheduler stage.

---
 rtl/row_hit_chain_builder.sv | 165 ++++++++++++++++
 tb/tb_row_hit_chain_builder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/row_hit_chain_builder.sv
// Walks a closed request batch and links same-row requests into arrival-ordered chains,
// reporting each chain head and the number of chains to the scheduler.
module row_hit_chain_builder #(
  parameter int MAX_REQUESTS  = 16,
  parameter int ID_WIDTH      = 4,
  parameter int CNT_WIDTH     = ID_WIDTH + 1,
  parameter int HIT_TAG_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [CNT_WIDTH-1:0]     num_requests_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [CNT_WIDTH-1:0]     num_chains_o,
  output logic [ID_WIDTH-1:0]      rd_addr_o,
  input  logic [HIT_TAG_WIDTH-1:0] rd_hit_tag_i,
  output logic                     cam_lookup_en_o,
  output logic [HIT_TAG_WIDTH-1:0] cam_lookup_tag_o,
  input  logic                     cam_hit_i,
  input  logic [ID_WIDTH-1:0]      cam_hit_addr_i,
  output logic                     chain_wr_en_o,
  output logic [ID_WIDTH-1:0]      chain_wr_addr_o,
  output logic [ID_WIDTH-1:0]      chain_wr_data_o,
  output logic                     head_valid_o,
  output logic [ID_WIDTH-1:0]      head_id_o
);

  typedef enum logic [2:0] {IDLE, RD, CAM, LINK, DONE} state_e;

  state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]  idx_q, idx_d;
  logic [ID_WIDTH-1:0]  h_lat_q, h_lat_d;
  logic [CNT_WIDTH-1:0] n_lat_q, n_lat_d;
  logic [CNT_WIDTH-1:0] num_chains_q, num_chains_d;
  logic                 miss_lat_q, miss_lat_d;
  logic                 err_q, err_d;

  // Tail of the chain rooted at each head index; only read after being written in this walk.
  logic [ID_WIDTH-1:0]  tail_q [MAX_REQUESTS];
  logic                 tail_we;
  logic [ID_WIDTH-1:0]  tail_waddr;

  logic head_case;
  logic last_req;

  assign head_case = miss_lat_q || (h_lat_q >= idx_q);
  assign last_req  = (CNT_WIDTH'(idx_q) == (n_lat_q - CNT_WIDTH'(1)));

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    h_lat_d          = h_lat_q;
    n_lat_d          = n_lat_q;
    num_chains_d     = num_chains_q;
    miss_lat_d       = miss_lat_q;
    err_d            = err_q;
    tail_we          = 1'b0;
    tail_waddr       = idx_q;
    done_o           = 1'b0;
    cam_lookup_en_o  = 1'b0;
    cam_lookup_tag_o = '0;
    chain_wr_en_o    = 1'b0;
    chain_wr_addr_o  = '0;
    chain_wr_data_o  = '0;
    head_valid_o     = 1'b0;
    head_id_o        = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_lat_d      = num_requests_i;
          idx_d        = '0;
          num_chains_d = '0;
          err_d        = 1'b0;
          state_d      = (num_requests_i != '0) ? RD : DONE;
        end
      end
      RD: state_d = CAM;
      CAM: begin
        cam_lookup_en_o  = 1'b1;
        cam_lookup_tag_o = rd_hit_tag_i;
        h_lat_d          = cam_hit_addr_i;
        miss_lat_d       = !cam_hit_i;
        state_d          = LINK;
      end
      LINK: begin
        tail_we = 1'b1;
        if (head_case) begin
          tail_waddr   = idx_q;
          head_valid_o = 1'b1;
          head_id_o    = idx_q;
          num_chains_d = num_chains_q + CNT_WIDTH'(1);
          if (miss_lat_q || (h_lat_q > idx_q)) err_d = 1'b1;
        end else begin
          tail_waddr      = h_lat_q;
          chain_wr_en_o   = 1'b1;
          chain_wr_addr_o = tail_q[h_lat_q];
          chain_wr_data_o = idx_q;
        end
        if (last_req) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + ID_WIDTH'(1);
          state_d = RD;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything: drop back to IDLE with no side effects this cycle.
    if (abort_i) begin
      state_d      = IDLE;
      idx_d        = idx_q;
      h_lat_d      = h_lat_q;
      n_lat_d      = n_lat_q;
      num_chains_d = num_chains_q;
      miss_lat_d   = miss_lat_q;
      err_d        = err_q;
      tail_we      = 1'b0;
      done_o       = 1'b0;
      chain_wr_en_o   = 1'b0;
      chain_wr_addr_o = '0;
      chain_wr_data_o = '0;
      head_valid_o    = 1'b0;
      head_id_o       = '0;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;
  assign num_chains_o = num_chains_q;
  assign rd_addr_o    = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      h_lat_q      <= '0;
      n_lat_q      <= '0;
      num_chains_q <= '0;
      miss_lat_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      h_lat_q      <= h_lat_d;
      n_lat_q      <= n_lat_d;
      num_chains_q <= num_chains_d;
      miss_lat_q   <= miss_lat_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tail_we) tail_q[tail_waddr] <= idx_q;
  end

endmodule

// File: tb/tb_row_hit_chain_builder.sv
// Directed bench: models the request buffer read port and hit-tag CAM, records strobes
// per cycle after start, and compares them against hand-computed schedules.
module tb_row_hit_chain_builder;
  localparam int IDW = 4;
  localparam int CW  = 5;
  localparam int TW  = 20;
  localparam logic [TW-1:0] TAG_A = 20'h0A0A0;
  localparam logic [TW-1:0] TAG_B = 20'h0B0B0;
  localparam logic [TW-1:0] TAG_C = 20'h0C0C0;
  localparam logic [TW-1:0] TAG_D = 20'h0D0D0;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [CW-1:0]  numReq = '0;
  logic           busy, done, err;
  logic [CW-1:0]  numChains;
  logic [IDW-1:0] rdAddr;
  logic [TW-1:0]  rdTag = '0;
  logic           camEn;
  logic [TW-1:0]  camTag;
  logic           camHit;
  logic [IDW-1:0] camAddr;
  logic           wrEn;
  logic [IDW-1:0] wrAddr, wrData;
  logic           headValid;
  logic [IDW-1:0] headId;

  logic [TW-1:0] tbTags [16];
  int cfgN = 0;
  int missIdx = -1;
  int checks = 0;
  int failures = 0;

  int headCycQ[$], headIdQ[$], wrCycQ[$], wrAQ[$], wrDQ[$], doneCycQ[$];
  logic busyHist [64];
  logic errHist [64];
  int   chainsHist [64];

  row_hit_chain_builder dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .num_requests_i(numReq),
    .busy_o(busy), .done_o(done), .err_o(err), .num_chains_o(numChains),
    .rd_addr_o(rdAddr), .rd_hit_tag_i(rdTag),
    .cam_lookup_en_o(camEn), .cam_lookup_tag_o(camTag),
    .cam_hit_i(camHit), .cam_hit_addr_i(camAddr),
    .chain_wr_en_o(wrEn), .chain_wr_addr_o(wrAddr), .chain_wr_data_o(wrData),
    .head_valid_o(headValid), .head_id_o(headId)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdTag <= tbTags[rdAddr];

  // Lowest matching index within the batch, with an optional forced miss for one request.
  always_comb begin
    camHit  = 1'b0;
    camAddr = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i < cfgN && tbTags[i] == camTag) begin
        camHit  = 1'b1;
        camAddr = IDW'(i);
      end
    end
    if (missIdx >= 0 && camEn && int'(rdAddr) == missIdx) camHit = 1'b0;
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qAt(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic setTags(input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                         input logic [TW-1:0] t2, input logic [TW-1:0] t3);
    for (int i = 0; i < 16; i++) tbTags[i] = TW'(20'h10000 + i);
    tbTags[0] = t0; tbTags[1] = t1; tbTags[2] = t2; tbTags[3] = t3;
  endtask

  task automatic applyStimulus(input int n, input int cycles, input int abortC,
                               input int startC, input int rstC);
    headCycQ.delete(); headIdQ.delete(); wrCycQ.delete();
    wrAQ.delete(); wrDQ.delete(); doneCycQ.delete();
    for (int i = 0; i < 64; i++) begin
      busyHist[i] = 1'b0; errHist[i] = 1'b0; chainsHist[i] = -1;
    end
    cfgN = n;
    @(negedge clk);
    numReq = CW'(n);
    start  = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      start = 1'b0;
      busyHist[c]   = busy;
      errHist[c]    = err;
      chainsHist[c] = int'(numChains);
      if (headValid) begin headCycQ.push_back(c); headIdQ.push_back(int'(headId)); end
      if (wrEn) begin
        wrCycQ.push_back(c); wrAQ.push_back(int'(wrAddr)); wrDQ.push_back(int'(wrData));
      end
      if (done) doneCycQ.push_back(c);
      abort = (c == abortC);
      start = (c == startC);
      if (c == rstC) begin
        rst_n = 1'b0;
        #1;
        checkOutput("midRstCtl", int'({busy, done, err, numChains, rdAddr, camEn, wrEn, headValid}), 0);
        checkOutput("midRstTag", int'(camTag), 0);
        checkOutput("midRstIds", int'({wrAddr, wrData, headId}), 0);
      end
    end
    abort = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    setTags(TAG_A, TAG_B, TAG_A, TAG_A);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstCtl", int'({busy, done, err, numChains, rdAddr, camEn, wrEn, headValid}), 0);
    checkOutput("rstTag", int'(camTag), 0);
    checkOutput("rstIds", int'({wrAddr, wrData, headId}), 0);
    rst_n = 1'b1;

    // N=0
    applyStimulus(0, 4, -1, -1, -1);
    checkOutput("n0DoneCnt", doneCycQ.size(), 1);
    checkOutput("n0DoneCyc", qAt(doneCycQ, 0), 0);
    checkOutput("n0Busy0", int'(busyHist[0]), 1);
    checkOutput("n0Busy1", int'(busyHist[1]), 0);
    checkOutput("n0Heads", headCycQ.size(), 0);
    checkOutput("n0Writes", wrCycQ.size(), 0);
    checkOutput("n0Chains", chainsHist[0], 0);

    // N=4, tags A,B,A,A
    setTags(TAG_A, TAG_B, TAG_A, TAG_A);
    applyStimulus(4, 15, -1, -1, -1);
    checkOutput("abHeadCnt", headCycQ.size(), 2);
    checkOutput("abHead0Cyc", qAt(headCycQ, 0), 2);
    checkOutput("abHead0Id", qAt(headIdQ, 0), 0);
    checkOutput("abHead1Cyc", qAt(headCycQ, 1), 5);
    checkOutput("abHead1Id", qAt(headIdQ, 1), 1);
    checkOutput("abWrCnt", wrCycQ.size(), 2);
    checkOutput("abWr0Cyc", qAt(wrCycQ, 0), 8);
    checkOutput("abWr0Addr", qAt(wrAQ, 0), 0);
    checkOutput("abWr0Data", qAt(wrDQ, 0), 2);
    checkOutput("abWr1Cyc", qAt(wrCycQ, 1), 11);
    checkOutput("abWr1Addr", qAt(wrAQ, 1), 2);
    checkOutput("abWr1Data", qAt(wrDQ, 1), 3);
    checkOutput("abDoneCnt", doneCycQ.size(), 1);
    checkOutput("abDoneCyc", qAt(doneCycQ, 0), 12);
    checkOutput("abChains", chainsHist[12], 2);
    checkOutput("abErr", int'(errHist[12]), 0);
    checkOutput("abBusy12", int'(busyHist[12]), 1);
    checkOutput("abBusy13", int'(busyHist[13]), 0);

    // N=16, all distinct
    for (int i = 0; i < 16; i++) tbTags[i] = TW'(20'h20000 + i);
    applyStimulus(16, 51, -1, -1, -1);
    checkOutput("fullHeadCnt", headCycQ.size(), 16);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("fullHead%0dCyc", k), qAt(headCycQ, k), 3 * k + 2);
      checkOutput($sformatf("fullHead%0dId", k), qAt(headIdQ, k), k);
    end
    checkOutput("fullWrCnt", wrCycQ.size(), 0);
    checkOutput("fullDoneCyc", qAt(doneCycQ, 0), 48);
    checkOutput("fullChains", chainsHist[48], 16);

    // N=4, forced CAM miss on request 2: it heads its own chain, request 3 links to tail[0]
    setTags(TAG_A, TAG_B, TAG_A, TAG_A);
    missIdx = 2;
    applyStimulus(4, 15, -1, -1, -1);
    missIdx = -1;
    checkOutput("missHeadCnt", headCycQ.size(), 3);
    checkOutput("missHead2Cyc", qAt(headCycQ, 2), 8);
    checkOutput("missHead2Id", qAt(headIdQ, 2), 2);
    checkOutput("missWrCnt", wrCycQ.size(), 1);
    checkOutput("missWrCyc", qAt(wrCycQ, 0), 11);
    checkOutput("missWrData", qAt(wrDQ, 0), 3);
    checkOutput("missErrDone", int'(errHist[12]), 1);
    checkOutput("missErrAfter", int'(errHist[14]), 1);
    checkOutput("missChains", chainsHist[12], 3);

    // N=6 aborted in cycle 7, then N=2 runs normally
    setTags(TAG_A, TAG_B, TAG_A, TAG_A);
    tbTags[4] = TAG_C; tbTags[5] = TAG_D;
    applyStimulus(6, 12, 7, -1, -1);
    checkOutput("abortErrCleared", int'(errHist[0]), 0);
    checkOutput("abortBusy7", int'(busyHist[7]), 1);
    checkOutput("abortBusy8", int'(busyHist[8]), 0);
    checkOutput("abortDoneCnt", doneCycQ.size(), 0);
    checkOutput("abortWrCnt", wrCycQ.size(), 0);
    checkOutput("abortHeadCnt", headCycQ.size(), 2);
    checkOutput("abortChainsHold", chainsHist[11], 2);
    applyStimulus(2, 9, -1, -1, -1);
    checkOutput("postAbortDoneCyc", qAt(doneCycQ, 0), 6);
    checkOutput("postAbortHeadCnt", headCycQ.size(), 2);
    checkOutput("postAbortChains", chainsHist[6], 2);

    // start during a walk is ignored
    setTags(TAG_A, TAG_B, TAG_A, TAG_A);
    applyStimulus(4, 15, -1, 4, -1);
    checkOutput("ignStartDoneCnt", doneCycQ.size(), 1);
    checkOutput("ignStartDoneCyc", qAt(doneCycQ, 0), 12);
    checkOutput("ignStartWrCnt", wrCycQ.size(), 2);

    // reset in cycle 5 of a walk
    applyStimulus(4, 10, -1, -1, 5);
    checkOutput("rstDoneCnt", doneCycQ.size(), 0);
    checkOutput("rstBusy6", int'(busyHist[6]), 0);
    checkOutput("rstChains", chainsHist[9], 0);
    checkOutput("rstWrCnt", wrCycQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
